pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, 16, width of program counter and jump target.
REQ-002 Parameter STACK_DEPTH, 16, number of return-address entries (>=2).
REQ-003 Parameter IN_W, 16, width of switch input capture.
REQ-004 Parameter TIMEOUT_CYC, 1000, wait-state timeout in clk cycles; used only with the macro in REQ-027.
REQ-005 Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
REQ-006 Ports, as name  direction  width  meaning:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  3  0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 WAIT_IN, 6 WAIT_DLY, 7 treated as NEXT
- cond  in  1  branch condition
- target  in  PC_W  jump/branch/call destination
- ent  in  1  active-low entry key
- sw_in  in  IN_W  switch data
- delay_busy  in  1  high while the display delay runs
- pc  out  PC_W  current program counter
- in_data  out  IN_W  last captured switch value
- stack_level  out  clog2(STACK_DEPTH+1)  occupied entries
- busy  out  1  state is not RUN
- ovf / unf  out  1 each  sticky overflow / underflow flags
- trap  out  1  state is TRAP
- timeout  out  1  sticky wait-timeout flag

Function
REQ-007 FSM states: RUN, WAIT_IN, WAIT_DLY, TRAP; `op` is decoded only in RUN.
REQ-008 NEXT: pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0).
REQ-009 JUMP: pc <= target.
REQ-010 BRANCH: pc <= target when cond=1, else pc+1.
REQ-011 CALL with stack_level<STACK_DEPTH: push pc+1, stack_level+1, pc <= target, all in one cycle.
REQ-012 CALL with stack full: no push; ovf <= 1; pc holds; next state TRAP.
REQ-013 RET with stack_level>0: pc <= top entry; stack_level-1.
REQ-014 RET with stack empty: unf <= 1; pc holds; next state TRAP.
REQ-015 Stack is LIFO; a popped entry is never returned again without a new push.
REQ-016 WAIT_IN entered from RUN: pc holds; `armed` cleared.
REQ-017 In WAIT_IN, ent=0 sets `armed`. ent=1 with armed=1 does all of the following in that cycle: in_data <= sw_in, pc <= pc+1, state RUN.
REQ-018 A key already released on entry to WAIT_IN does not advance; a full press and release is required. Minimum dwell is 2 cycles.
REQ-019 WAIT_DLY entered from RUN: pc holds. Exit to RUN with pc+1 on the first cycle after entry with delay_busy=0. The entry cycle itself never exits, so minimum dwell is 2 cycles.
REQ-020 TRAP: pc, stack and in_data frozen; all ops ignored; only reset leaves TRAP.
REQ-021 busy = (state != RUN); trap = (state == TRAP). Both are decoded from the registered state.
REQ-022 All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 at a clk edge sets: pc=0, state RUN, stack_level=0, in_data=0, ovf=unf=timeout=0, armed=0, timeout counter=0.
REQ-024 Reset has priority over every op and state, including mid-wait and TRAP.
REQ-025 Stack entry contents are don't-care after reset; only stack_level is cleared.
REQ-026 Outputs are valid on the first edge after reset deasserts.

Configuration
REQ-027 Macro PC_SEQ_WAIT_TIMEOUT_EN defined: a counter runs in WAIT_IN and WAIT_DLY. After TIMEOUT_CYC cycles in the state without a normal exit, the block sets timeout <= 1, does pc <= pc+1, returns to RUN, and leaves in_data unchanged. A normal exit in the same cycle wins and does not set timeout.
REQ-028 Macro absent: waits are unbounded; timeout is tied to 0; the counter is not synthesised.

Verification
REQ-029 Reset, then NEXT ×3, JUMP target=0x0100, BRANCH cond=0 -> pc sequence 1, 2, 3, 0x0100, 0x0101.
REQ-030 STACK_DEPTH=4: CALLs at pc 0, 0x10, 0x20, 0x30 (target +0x10 each), then RET ×4 -> pc 0x31, 0x21, 0x11, 1; stack_level 4→0. A 5th CALL at full stack -> ovf=1, trap=1, pc frozen.
REQ-031 RET with empty stack at pc=5 -> unf=1, trap=1, pc=5. JUMP next cycle -> pc still 5. reset -> pc=0, flags 0.
REQ-032 WAIT_IN at pc=7 with ent=1 held 10 cycles -> pc=7, busy=1. ent=0 for 3 cycles, then 1 with sw_in=0xA5A5 -> in_data=0xA5A5, pc=8, busy=0.
REQ-033 WAIT_DLY with delay_busy=1 for 20 cycles -> pc held; delay_busy=0 -> pc+1 on the next edge. reset asserted mid-wait -> pc=0, state RUN.
REQ-034 With PC_SEQ_WAIT_TIMEOUT_EN and TIMEOUT_CYC=8: WAIT_IN, ent held 1 -> after 8 cycles timeout=1, pc+1, in_data unchanged. pc=0xFFFF, NEXT -> pc=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction/handshake bundle between a controller and pc_sequencer.
// The controller drives op/target/keys; the sequencer returns pc and status.
interface pc_sequencer_if #(
  parameter int PC_W        = 16,
  parameter int IN_W        = 16,
  parameter int STACK_DEPTH = 16
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [2:0]       op;
  logic             cond;
  logic [PC_W-1:0]  target;
  logic             ent;
  logic [IN_W-1:0]  sw_in;
  logic             delay_busy;

  logic [PC_W-1:0]  pc;
  logic [IN_W-1:0]  in_data;
  logic [LVL_W-1:0] stack_level;
  logic             busy;
  logic             ovf;
  logic             unf;
  logic             trap;
  logic             timeout;

  modport master (
    output op, cond, target, ent, sw_in, delay_busy,
    input  pc, in_data, stack_level, busy, ovf, unf, trap, timeout
  );

  modport slave (
    input  op, cond, target, ent, sw_in, delay_busy,
    output pc, in_data, stack_level, busy, ovf, unf, trap, timeout
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call stack, key/delay wait states and a trap state.
// Define PC_SEQ_WAIT_TIMEOUT_EN to bound both wait states by TIMEOUT_CYC cycles.
module pc_sequencer #(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 16,
  parameter int IN_W        = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_BRANCH   = 3'd2;
  localparam logic [2:0] OP_CALL     = 3'd3;
  localparam logic [2:0] OP_RET      = 3'd4;
  localparam logic [2:0] OP_WAIT_IN  = 3'd5;
  localparam logic [2:0] OP_WAIT_DLY = 3'd6;

  typedef enum logic [1:0] {S_RUN, S_WAIT_IN, S_WAIT_DLY, S_TRAP} state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic [IN_W-1:0]  in_data;
  logic [LVL_W-1:0] stack_level;
  logic [LVL_W-1:0] lvl_dec;
  logic             ovf;
  logic             unf;
  logic             armed;
  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
  logic [PC_W-1:0]  stack_top;
  logic             in_wait;
  logic             wait_exit;
  logic             tmo_hit;

  assign pc_inc    = pc + PC_ONE;
  assign lvl_dec   = stack_level - LVL_ONE;
  assign stack_top = stack_mem[lvl_dec[IDX_W-1:0]];
  assign in_wait   = (state == S_WAIT_IN) || (state == S_WAIT_DLY);

  // armed means "key was seen pressed" in WAIT_IN and "entry cycle done" in WAIT_DLY
  always_comb begin
    wait_exit = 1'b0;
    case (state)
      S_WAIT_IN:  wait_exit = armed && bus.ent;
      S_WAIT_DLY: wait_exit = armed && !bus.delay_busy;
      default:    wait_exit = 1'b0;
    endcase
  end

`ifdef PC_SEQ_WAIT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout;

  // A normal exit in the same cycle as expiry takes precedence
  assign tmo_hit = in_wait && !wait_exit && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (in_wait) tmo_cnt <= tmo_cnt + TMO_ONE;
      else         tmo_cnt <= '0;
      if (tmo_hit) timeout <= 1'b1;
    end
  end

  assign bus.timeout = timeout;
`else
  assign tmo_hit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      pc          <= '0;
      stack_level <= '0;
      in_data     <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      armed       <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          case (bus.op)
            OP_JUMP:   pc <= bus.target;
            OP_BRANCH: pc <= bus.cond ? bus.target : pc_inc;
            OP_CALL: begin
              if (stack_level != LVL_FULL) begin
                stack_mem[stack_level[IDX_W-1:0]] <= pc_inc;
                stack_level <= stack_level + LVL_ONE;
                pc          <= bus.target;
              end else begin
                ovf   <= 1'b1;
                state <= S_TRAP;
              end
            end
            OP_RET: begin
              if (stack_level != '0) begin
                pc          <= stack_top;
                stack_level <= lvl_dec;
              end else begin
                unf   <= 1'b1;
                state <= S_TRAP;
              end
            end
            OP_WAIT_IN: begin
              state <= S_WAIT_IN;
              armed <= 1'b0;
            end
            OP_WAIT_DLY: begin
              state <= S_WAIT_DLY;
              armed <= 1'b0;
            end
            default: pc <= pc_inc;
          endcase
        end
        S_WAIT_IN: begin
          if (wait_exit) begin
            in_data <= bus.sw_in;
            pc      <= pc_inc;
            state   <= S_RUN;
          end else if (tmo_hit) begin
            pc    <= pc_inc;
            state <= S_RUN;
          end else if (!bus.ent) begin
            armed <= 1'b1;
          end
        end
        S_WAIT_DLY: begin
          if (wait_exit || tmo_hit) begin
            pc    <= pc_inc;
            state <= S_RUN;
          end else begin
            armed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc;
  assign bus.in_data     = in_data;
  assign bus.stack_level = stack_level;
  assign bus.ovf         = ovf;
  assign bus.unf         = unf;
  assign bus.busy        = (state != S_RUN);
  assign bus.trap        = (state == S_TRAP);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  localparam int PC_W = 16;
  localparam int IN_W = 16;
  localparam int DEPTH = 4;
  localparam int TMO_CYC = 8;
`ifdef PC_SEQ_WAIT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int M_RUN = 0, M_WIN = 1, M_WDLY = 2, M_TRAP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .IN_W(IN_W), .STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .IN_W(IN_W), .TIMEOUT_CYC(TMO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_in;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_unf, m_tmo;
  int          m_mode;
  bit          m_seen;
  int          m_dwell;

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s_%s observed=%0h expected=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model(input logic rst, input logic [2:0] op, input logic c, input logic [15:0] tgt,
                       input logic e, input logic [15:0] sw, input logic db);
    if (rst) begin
      m_pc = '0; m_in = '0; m_stk.delete();
      m_ovf = 0; m_unf = 0; m_tmo = 0;
      m_mode = M_RUN; m_seen = 0; m_dwell = 0;
      return;
    end
    case (m_mode)
      M_RUN: begin
        if (op == 3'd1) m_pc = tgt;
        else if (op == 3'd2) m_pc = c ? tgt : m_pc + 16'd1;
        else if (op == 3'd3) begin
          if (m_stk.size() < DEPTH) begin m_stk.push_back(m_pc + 16'd1); m_pc = tgt; end
          else begin m_ovf = 1; m_mode = M_TRAP; end
        end else if (op == 3'd4) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_unf = 1; m_mode = M_TRAP; end
        end else if (op == 3'd5) begin m_mode = M_WIN; m_seen = 0; m_dwell = 0; end
        else if (op == 3'd6) begin m_mode = M_WDLY; m_dwell = 0; end
        else m_pc = m_pc + 16'd1;
      end
      M_WIN: begin
        m_dwell++;
        if (m_seen && e) begin m_in = sw; m_pc = m_pc + 16'd1; m_mode = M_RUN; end
        else if (TMO_EN && m_dwell == TMO_CYC) begin m_tmo = 1; m_pc = m_pc + 16'd1; m_mode = M_RUN; end
        else if (!e) m_seen = 1;
      end
      M_WDLY: begin
        m_dwell++;
        if (m_dwell > 1 && !db) begin m_pc = m_pc + 16'd1; m_mode = M_RUN; end
        else if (TMO_EN && m_dwell == TMO_CYC) begin m_tmo = 1; m_pc = m_pc + 16'd1; m_mode = M_RUN; end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("in_data", 32'(bus.in_data), 32'(m_in));
    chk("level", 32'(bus.stack_level), 32'(m_stk.size()));
    chk("busy", 32'(bus.busy), 32'(m_mode != M_RUN));
    chk("trap", 32'(bus.trap), 32'(m_mode == M_TRAP));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    chk("unf", 32'(bus.unf), 32'(m_unf));
    chk("timeout", 32'(bus.timeout), 32'(m_tmo));
  endtask

  task automatic step(input logic rst, input logic [2:0] op, input logic c, input logic [15:0] tgt,
                      input logic e, input logic [15:0] sw, input logic db);
    @(negedge clk);
    reset = rst; bus.op = op; bus.cond = c; bus.target = tgt;
    bus.ent = e; bus.sw_in = sw; bus.delay_busy = db;
    @(posedge clk);
    model(rst, op, c, tgt, e, sw, db);
    #1 check_all();
  endtask

  task automatic op_step(input logic [2:0] op, input logic [15:0] tgt);
    step(1'b0, op, 1'b0, tgt, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 3'd0; bus.cond = 1'b0; bus.target = '0;
    bus.ent = 1'b1; bus.sw_in = '0; bus.delay_busy = 1'b0;

    phase = "reset";
    do_reset();
    do_reset();
    chk("pc_zero", 32'(bus.pc), 32'h0);

    phase = "seq";
    op_step(3'd0, 16'h0);
    op_step(3'd0, 16'h0);
    op_step(3'd0, 16'h0);
    chk("pc3", 32'(bus.pc), 32'h3);
    op_step(3'd1, 16'h0100);
    chk("jump", 32'(bus.pc), 32'h0100);
    op_step(3'd2, 16'h0400);
    chk("br_nt", 32'(bus.pc), 32'h0101);
    step(1'b0, 3'd2, 1'b1, 16'h0400, 1'b1, 16'h0, 1'b0);
    chk("br_t", 32'(bus.pc), 32'h0400);
    op_step(3'd7, 16'h0);
    chk("op7", 32'(bus.pc), 32'h0401);

    phase = "stack";
    do_reset();
    for (int i = 1; i <= 4; i++) op_step(3'd3, 16'(i * 16));
    chk("full_lvl", 32'(bus.stack_level), 32'd4);
    op_step(3'd4, 16'h0);
    chk("ret1", 32'(bus.pc), 32'h31);
    op_step(3'd4, 16'h0);
    op_step(3'd4, 16'h0);
    chk("ret3", 32'(bus.pc), 32'h11);
    op_step(3'd4, 16'h0);
    chk("ret4", 32'(bus.pc), 32'h1);
    chk("empty_lvl", 32'(bus.stack_level), 32'd0);
    for (int i = 1; i <= 4; i++) op_step(3'd3, 16'(i * 16 + 1));
    op_step(3'd3, 16'h0999);
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    chk("ovf_trap", 32'(bus.trap), 32'd1);
    chk("ovf_pc", 32'(bus.pc), 32'h41);

    phase = "unf";
    do_reset();
    op_step(3'd1, 16'h0005);
    op_step(3'd4, 16'h0);
    chk("unf_flag", 32'(bus.unf), 32'd1);
    chk("unf_pc", 32'(bus.pc), 32'h5);
    op_step(3'd1, 16'h0077);
    chk("trap_frz", 32'(bus.pc), 32'h5);
    do_reset();
    chk("clr_unf", 32'(bus.unf), 32'd0);

    phase = "wait_in";
    op_step(3'd1, 16'h0007);
    op_step(3'd5, 16'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 3'd1, 1'b0, 16'h0333, 1'b1, 16'h1111, 1'b0);
`ifndef PC_SEQ_WAIT_TIMEOUT_EN
    chk("hold_pc", 32'(bus.pc), 32'h7);
    chk("hold_busy", 32'(bus.busy), 32'd1);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h2222, 1'b0);
    step(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'hA5A5, 1'b0);
`ifndef PC_SEQ_WAIT_TIMEOUT_EN
    chk("cap", 32'(bus.in_data), 32'hA5A5);
    chk("adv_pc", 32'(bus.pc), 32'h8);
`endif

    phase = "wait_dly";
    op_step(3'd1, 16'h0200);
    op_step(3'd6, 16'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
    op_step(3'd6, 16'h0);
    step(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("entry_hold", 32'(bus.busy), 32'd1);
    step(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b1);
    do_reset();
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);

`ifdef PC_SEQ_WAIT_TIMEOUT_EN
    phase = "tmo";
    op_step(3'd1, 16'h0020);
    op_step(3'd5, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
    chk("tmo_flag", 32'(bus.timeout), 32'd1);
    chk("tmo_pc", 32'(bus.pc), 32'h21);
    chk("tmo_in", 32'(bus.in_data), 32'h0);
`endif

    phase = "wrap";
    op_step(3'd1, 16'hFFFF);
    op_step(3'd0, 16'h0);
    chk("wrap_pc", 32'(bus.pc), 32'h0);

    phase = "rand";
    for (int i = 0; i < 800; i++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      step(r, 3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 2) != 0), 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
